write_back: RTL and testbench

- Final pipeline stage. Consumes the execute stage's output bundle.
- Retires each instruction: register-file writeback, flags writeback, or a memory store over a ready/request handshake.
- Stalls the execute stage via in_hold while a store is outstanding. Keeps a retired-instruction counter and a sticky memory-timeout error.

---
 rtl/write_back.sv | 133 +++++++++++++
 tb/tb_write_back.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/write_back.sv
// rtl/write_back.sv - final pipeline stage: register/flags writeback and store handshake
module write_back #(
    parameter int REG_BITS    = 5,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_is_valid,
    input  logic [31:0]         in_pc,
    input  logic [REG_BITS-1:0] in_destination_register,
    input  logic                in_is_writing_memory,
    input  logic [3:0]          in_flags,
    input  logic [31:0]         in_destination_value,
    input  logic [31:0]         in_adjustment_value,
    input  logic                in_has_flushed,
    output logic                in_hold,
    input  logic [31:0]         address_base,
    output logic                rf_write_enable,
    output logic [REG_BITS-1:0] rf_write_index,
    output logic [31:0]         rf_write_value,
    output logic                flags_write_enable,
    output logic [3:0]          flags_value,
    output logic                mem_request,
    output logic [31:0]         mem_address,
    output logic [31:0]         mem_data,
    input  logic                mem_ready,
    output logic                mem_error,
    output logic [31:0]         retired_count,
    output logic [31:0]         retired_pc
);
    localparam logic S_IDLE     = 1'b0;
    localparam logic S_MEM_WAIT = 1'b1;

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);

    logic                r_state;
    logic [TW-1:0]       r_timer;
    logic                r_rf_write_enable;
    logic [REG_BITS-1:0] r_rf_write_index;
    logic [31:0]         r_rf_write_value;
    logic                r_flags_write_enable;
    logic [3:0]          r_flags_value;
    logic                r_mem_request;
    logic [31:0]         r_mem_address;
    logic [31:0]         r_mem_data;
    logic                r_mem_error;
    logic [31:0]         r_retired_count;
    logic [31:0]         r_retired_pc;
    logic [3:0]          r_store_flags;
    logic [31:0]         r_store_pc;

    logic [31:0]         w_store_address;
    logic                w_accept;

    assign w_store_address = address_base + in_adjustment_value;
    assign w_accept        = (r_state == S_IDLE) && in_is_valid && !in_has_flushed;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state              <= S_IDLE;
            r_timer              <= '0;
            r_rf_write_enable    <= 1'b0;
            r_rf_write_index     <= '0;
            r_rf_write_value     <= '0;
            r_flags_write_enable <= 1'b0;
            r_flags_value        <= '0;
            r_mem_request        <= 1'b0;
            r_mem_address        <= '0;
            r_mem_data           <= '0;
            r_mem_error          <= 1'b0;
            r_retired_count      <= '0;
            r_retired_pc         <= '0;
            r_store_flags        <= '0;
            r_store_pc           <= '0;
        end else begin
            r_rf_write_enable    <= 1'b0;
            r_flags_write_enable <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept && in_is_writing_memory) begin
                    r_mem_address <= w_store_address;
                    r_mem_data    <= in_destination_value;
                    r_store_flags <= in_flags;
                    r_store_pc    <= in_pc;
                    r_mem_request <= 1'b1;
                    r_timer       <= '0;
                    r_state       <= S_MEM_WAIT;
                end else if (w_accept) begin
                    r_flags_write_enable <= 1'b1;
                    r_flags_value        <= in_flags;
                    if (in_destination_register != '0) begin
                        r_rf_write_enable <= 1'b1;
                        r_rf_write_index  <= in_destination_register;
                        r_rf_write_value  <= in_destination_value;
                    end
                    r_retired_count <= r_retired_count + 32'd1;
                    r_retired_pc    <= in_pc;
                end
            end else begin
                // mem_ready wins over the timeout on the final wait cycle
                if (mem_ready) begin
                    r_mem_request        <= 1'b0;
                    r_flags_write_enable <= 1'b1;
                    r_flags_value        <= r_store_flags;
                    r_retired_count      <= r_retired_count + 32'd1;
                    r_retired_pc         <= r_store_pc;
                    r_timer              <= '0;
                    r_state              <= S_IDLE;
                end else if (r_timer == TIMER_LAST) begin
                    r_mem_error   <= 1'b1;
                    r_mem_request <= 1'b0;
                    r_timer       <= '0;
                    r_state       <= S_IDLE;
                end else begin
                    r_timer <= r_timer + TW'(1);
                end
            end
        end
    end

    assign in_hold            = (r_state == S_MEM_WAIT);
    assign rf_write_enable    = r_rf_write_enable;
    assign rf_write_index     = r_rf_write_index;
    assign rf_write_value     = r_rf_write_value;
    assign flags_write_enable = r_flags_write_enable;
    assign flags_value        = r_flags_value;
    assign mem_request        = r_mem_request;
    assign mem_address        = r_mem_address;
    assign mem_data           = r_mem_data;
    assign mem_error          = r_mem_error;
    assign retired_count      = r_retired_count;
    assign retired_pc         = r_retired_pc;
endmodule

// File: tb/tb_write_back.sv
// tb/tb_write_back.sv - write_back bench: directed cases plus random traffic against a retire model
module tb_write_back;
    localparam int RB = 5;
    localparam int TO = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_is_valid;
    logic [31:0]   in_pc;
    logic [RB-1:0] in_destination_register;
    logic          in_is_writing_memory;
    logic [3:0]    in_flags;
    logic [31:0]   in_destination_value;
    logic [31:0]   in_adjustment_value;
    logic          in_has_flushed;
    logic          in_hold;
    logic [31:0]   address_base;
    logic          rf_write_enable;
    logic [RB-1:0] rf_write_index;
    logic [31:0]   rf_write_value;
    logic          flags_write_enable;
    logic [3:0]    flags_value;
    logic          mem_request;
    logic [31:0]   mem_address;
    logic [31:0]   mem_data;
    logic          mem_ready;
    logic          mem_error;
    logic [31:0]   retired_count;
    logic [31:0]   retired_pc;

    write_back #(.REG_BITS(RB), .MEM_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .in_is_valid(in_is_valid), .in_pc(in_pc),
        .in_destination_register(in_destination_register),
        .in_is_writing_memory(in_is_writing_memory), .in_flags(in_flags),
        .in_destination_value(in_destination_value),
        .in_adjustment_value(in_adjustment_value), .in_has_flushed(in_has_flushed),
        .in_hold(in_hold), .address_base(address_base),
        .rf_write_enable(rf_write_enable), .rf_write_index(rf_write_index),
        .rf_write_value(rf_write_value), .flags_write_enable(flags_write_enable),
        .flags_value(flags_value), .mem_request(mem_request), .mem_address(mem_address),
        .mem_data(mem_data), .mem_ready(mem_ready), .mem_error(mem_error),
        .retired_count(retired_count), .retired_pc(retired_pc)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Model: an outstanding store is a pending record plus the number of wait cycles seen.
    bit            m_pending;
    int            m_waited;
    logic [31:0]   m_addr, m_data, m_pc;
    logic [3:0]    m_flags;
    bit            m_was_holding;
    logic          e_rf_we, e_fl_we, e_req, e_err;
    logic [RB-1:0] e_rf_idx;
    logic [31:0]   e_rf_val, e_count, e_rpc;
    logic [3:0]    e_fl_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        m_was_holding = m_pending;
        e_rf_we = 1'b0;
        e_fl_we = 1'b0;
        if (reset) begin
            m_pending = 0; m_waited = 0; e_req = 0; e_err = 0;
            e_count = 0; e_rpc = 0;
        end else if (!m_pending) begin
            if (in_is_valid && !in_has_flushed) begin
                if (in_is_writing_memory) begin
                    m_pending = 1; m_waited = 0; e_req = 1;
                    m_addr = address_base + in_adjustment_value;
                    m_data = in_destination_value;
                    m_flags = in_flags; m_pc = in_pc;
                end else begin
                    e_fl_we = 1; e_fl_val = in_flags;
                    if (in_destination_register != 0) begin
                        e_rf_we = 1; e_rf_idx = in_destination_register;
                        e_rf_val = in_destination_value;
                    end
                    e_count = e_count + 1; e_rpc = in_pc;
                end
            end
        end else begin
            m_waited++;
            if (mem_ready) begin
                m_pending = 0; e_req = 0; e_fl_we = 1; e_fl_val = m_flags;
                e_count = e_count + 1; e_rpc = m_pc;
            end else if (m_waited == TO) begin
                m_pending = 0; e_req = 0; e_err = 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("in_hold", {31'd0, in_hold}, {31'd0, m_pending});
        chk("mem_request", {31'd0, mem_request}, {31'd0, e_req});
        chk("mem_error", {31'd0, mem_error}, {31'd0, e_err});
        chk("retired_count", retired_count, e_count);
        chk("retired_pc", retired_pc, e_rpc);
        chk("rf_write_enable", {31'd0, rf_write_enable}, {31'd0, e_rf_we});
        chk("flags_write_enable", {31'd0, flags_write_enable}, {31'd0, e_fl_we});
        if (e_rf_we) begin
            chk("rf_write_index", {27'd0, rf_write_index}, {27'd0, e_rf_idx});
            chk("rf_write_value", rf_write_value, e_rf_val);
        end
        if (e_fl_we) chk("flags_value", {28'd0, flags_value}, {28'd0, e_fl_val});
        if (e_req) begin
            chk("mem_address", mem_address, m_addr);
            chk("mem_data", mem_data, m_data);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_instr(input bit valid, input bit store, input bit flushed,
                             input logic [RB-1:0] dest, input logic [31:0] value,
                             input logic [3:0] flags, input logic [31:0] base,
                             input logic [31:0] adj, input logic [31:0] pc);
        in_is_valid = valid; in_is_writing_memory = store; in_has_flushed = flushed;
        in_destination_register = dest; in_destination_value = value;
        in_flags = flags; address_base = base; in_adjustment_value = adj; in_pc = pc;
    endtask

    task automatic rand_instr();
        set_instr($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) == 0,
                  ($urandom_range(0, 3) == 0) ? RB'(0) : RB'($urandom),
                  $urandom, 4'($urandom), $urandom, $urandom, $urandom);
    endtask

    initial begin
        m_pending = 0; m_waited = 0; m_was_holding = 0;
        e_req = 0; e_err = 0; e_count = 0; e_rpc = 0;
        e_rf_we = 0; e_fl_we = 0; e_rf_idx = 0; e_rf_val = 0; e_fl_val = 0;
        m_addr = 0; m_data = 0; m_pc = 0; m_flags = 0;
        reset = 1; mem_ready = 0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(); cycle();
        chk("reset_count_lit", retired_count, 32'd0);
        chk("reset_req_lit", {31'd0, mem_request}, 32'd0);
        reset = 0;

        // non-store with destination
        set_instr(1, 0, 0, 3, 32'h12345678, 4'b0101, 0, 0, 32'h100);
        cycle();
        chk("ns_rf_we_lit", {31'd0, rf_write_enable}, 32'd1);
        chk("ns_rf_idx_lit", {27'd0, rf_write_index}, 32'd3);
        chk("ns_rf_val_lit", rf_write_value, 32'h12345678);
        chk("ns_flags_lit", {28'd0, flags_value}, 32'h5);
        chk("ns_count_lit", retired_count, 32'd1);
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("ns_strobe_off_lit", {30'd0, rf_write_enable, flags_write_enable}, 32'd0);

        // non-store discarding to register 0
        set_instr(1, 0, 0, 0, 32'hFFFF, 4'b1000, 0, 0, 32'h104);
        cycle();
        chk("r0_rf_we_lit", {31'd0, rf_write_enable}, 32'd0);
        chk("r0_fl_we_lit", {31'd0, flags_write_enable}, 32'd1);
        chk("r0_count_lit", retired_count, 32'd2);

        // store retiring on its third wait cycle, next instruction held upstream
        set_instr(1, 1, 0, 2, 32'hCAFEBABE, 4'b0011, 32'h1000, 32'h10, 32'h108);
        cycle();
        set_instr(1, 0, 0, 7, 32'hA5A5, 4'b0001, 0, 0, 32'h10C);
        chk("st_req_lit", {31'd0, mem_request}, 32'd1);
        chk("st_addr_lit", mem_address, 32'h1010);
        chk("st_hold_lit", {31'd0, in_hold}, 32'd1);
        cycle(); cycle();
        chk("st_data_lit", mem_data, 32'hCAFEBABE);
        mem_ready = 1;
        cycle();
        mem_ready = 0;
        chk("st_done_req_lit", {31'd0, mem_request}, 32'd0);
        chk("st_done_count_lit", retired_count, 32'd3);
        chk("st_done_pc_lit", retired_pc, 32'h108);
        cycle();
        chk("held_rf_idx_lit", {27'd0, rf_write_index}, 32'd7);
        chk("held_count_lit", retired_count, 32'd4);

        // store that times out
        set_instr(1, 1, 0, 1, 32'h55, 4'b0000, 32'h20, 32'h4, 32'h200);
        cycle();
        set_instr(1, 0, 0, 9, 32'h99, 4'b0010, 0, 0, 32'h204);
        cycle(); cycle(); cycle();
        chk("to_req_still_lit", {31'd0, mem_request}, 32'd1);
        cycle();
        chk("to_req_drop_lit", {31'd0, mem_request}, 32'd0);
        chk("to_err_lit", {31'd0, mem_error}, 32'd1);
        chk("to_count_lit", retired_count, 32'd4);
        cycle();
        chk("to_err_sticky_lit", {31'd0, mem_error}, 32'd1);
        chk("to_next_count_lit", retired_count, 32'd5);

        // squashed instruction
        set_instr(1, 0, 1, 5, 32'h77, 4'b1111, 0, 0, 32'h300);
        cycle();
        chk("fl_strobes_lit", {30'd0, rf_write_enable, flags_write_enable}, 32'd0);
        chk("fl_count_lit", retired_count, 32'd5);

        // reset during the second wait cycle
        set_instr(1, 1, 0, 1, 32'h66, 4'b0100, 32'h40, 32'h0, 32'h400);
        cycle();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        chk("rst_req_lit", {31'd0, mem_request}, 32'd0);
        chk("rst_hold_lit", {31'd0, in_hold}, 32'd0);
        chk("rst_count_lit", retired_count, 32'd0);
        chk("rst_err_lit", {31'd0, mem_error}, 32'd0);

        // counter wrap
        force dut.r_retired_count = 32'hFFFFFFFF;
        #1;
        release dut.r_retired_count;
        e_count = 32'hFFFFFFFF;
        set_instr(1, 0, 0, 4, 32'h1, 4'b0001, 0, 0, 32'h500);
        cycle();
        chk("wrap_count_lit", retired_count, 32'd0);

        // random traffic with upstream hold honoured
        for (int i = 0; i < 3000; i++) begin
            if (!m_was_holding || reset) rand_instr();
            reset = ($urandom_range(0, 99) == 0);
            mem_ready = ($urandom_range(0, 9) < 3);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
